// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder: translates request fields into a 32-bit word
// and buffers up to two words in a small FIFO. Illegal ops are counted and dropped.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [1:0]  level,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_ORI = 4'd2,
        OP_LW  = 4'd3,
        OP_SW  = 4'd4,
        OP_BEQ = 4'd5,
        OP_LUI = 4'd6,
        OP_JAL = 4'd7,
        OP_JR  = 4'd8
    } op_e;

    logic [31:0] mem_q [2];
    logic        head_q;
    logic [1:0]  level_q, level_d;
    logic        illegal_q;
    logic [7:0]  illegal_cnt_q;

    logic        accept, pop, push, op_illegal;
    logic        wr_idx;
    logic [31:0] enc_word;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        enc_word   = 32'h0;
        op_illegal = 1'b0;
        case (op_e'(op))
            OP_ADD:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            OP_SUB:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            OP_ORI:  enc_word = {6'b001101, rs, rt, imm};
            OP_LW:   enc_word = {6'b100011, rs, rt, imm};
            OP_SW:   enc_word = {6'b101011, rs, rt, imm};
            OP_BEQ:  enc_word = {6'b000100, rs, rt, imm};
            OP_LUI:  enc_word = {6'b001111, 5'b00000, rt, imm};
            OP_JAL:  enc_word = {6'b000011, target};
            OP_JR:   enc_word = {6'b000000, rs, 15'b0, 6'b001000};
            default: op_illegal = 1'b1;
        endcase
    end

    assign in_ready  = !reset && (level_q != 2'd2);
    assign out_valid = (level_q != 2'd0);
    assign out_instr = mem_q[head_q];
    assign level     = level_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = illegal_cnt_q;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    assign push   = accept && !op_illegal;
    // Tail slot sits one past the head when a word is already buffered.
    assign wr_idx = head_q ^ level_q[0];

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 2'd1;
            2'b01:   level_d = level_q - 2'd1;
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the two FIFO
    // entries are reset as well because out_instr must read 0 during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0]      <= 32'h0;
            mem_q[1]      <= 32'h0;
            head_q        <= 1'b0;
            level_q       <= 2'd0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= 8'd0;
        end else begin
            if (push) begin
                mem_q[wr_idx] <= enc_word;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            level_q   <= level_d;
            illegal_q <= accept && op_illegal;
            if (accept && op_illegal && (illegal_cnt_q != 8'hFF)) begin
                illegal_cnt_q <= illegal_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  level;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int checks = 0;
    int errors = 0;

    instr_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .target     (target),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .level      (level),
        .illegal    (illegal),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg);
        in_valid = v;
        op       = o;
        rs       = s;
        rt       = t;
        rd       = d;
        imm      = i;
        target   = tg;
    endtask

    // Push one word with the consumer stalled, check the head, then drain it.
    task automatic push_pop(input string tag, input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg,
                            input logic [31:0] exp);
        req(1'b1, o, s, t, d, i, tg);
        out_ready = 1'b0;
        tick();
        check({tag, "_word"}, out_instr, exp);
        check({tag, "_lvl1"}, {30'b0, level}, 32'd1);
        req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        out_ready = 1'b1;
        tick();
        check({tag, "_lvl0"}, {30'b0, level}, 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic lvl_bad;

        reset     = 1'b1;
        out_ready = 1'b0;
        req(1'b1, 4'd12, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        #2;
        check("rst_level", {30'b0, level}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        tick();
        check("rst_no_illegal", {31'b0, illegal}, 32'd0);
        check("rst_cnt", {24'b0, illegal_cnt}, 32'd0);
        reset = 1'b0;
        req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("post_rst_illegal", {31'b0, illegal}, 32'd0);

        // add with consumer ready: visible next cycle, drained the cycle after
        req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h3FFFFFF);
        out_ready = 1'b1;
        tick();
        check("add_valid", {31'b0, out_valid}, 32'd1);
        check("add_word", out_instr, 32'h00221820);
        req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        tick();
        check("add_drained", {30'b0, level}, 32'd0);
        out_ready = 1'b0;

        push_pop("sub", 4'd1, 5'd1, 5'd2, 5'd3, 16'h5555, 26'h1234567, 32'h00221822);
        push_pop("lw",  4'd3, 5'd2, 5'd8, 5'd31, 16'h0010, 26'h2AAAAAA, 32'h8C480010);
        push_pop("sw",  4'd4, 5'd29, 5'd31, 5'd7, 16'hFFFC, 26'h0000001, 32'hAFBFFFFC);
        push_pop("jr",  4'd8, 5'd31, 5'd9, 5'd9, 16'hFFFF, 26'h3FFFFFF, 32'h03E00008);

        // lui then jal with consumer stalled fills the FIFO
        req(1'b1, 4'd6, 5'd17, 5'd4, 5'd9, 16'h1234, 26'h3FFFFFF);
        tick();
        req(1'b1, 4'd7, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'h0000C00);
        tick();
        check("full_level", {30'b0, level}, 32'd2);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_head", out_instr, 32'h3C041234);

        // beq at level 2 with a pop: blocked this cycle, taken the next
        req(1'b1, 4'd5, 5'd3, 5'd3, 5'd0, 16'hFFFE, 26'h0);
        out_ready = 1'b1;
        tick();
        check("beq_blocked_level", {30'b0, level}, 32'd1);
        check("jal_second_word", out_instr, 32'h0C000C00);
        tick();
        check("beq_pop_level", {30'b0, level}, 32'd1);
        check("beq_word", out_instr, 32'h1063FFFE);
        req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        tick();
        check("beq_drained", {30'b0, level}, 32'd0);

        // ori at level 1 with simultaneous pop
        out_ready = 1'b0;
        req(1'b1, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        req(1'b1, 4'd2, 5'd0, 5'd5, 5'd21, 16'hFFFF, 26'h155);
        out_ready = 1'b1;
        tick();
        check("ori_level", {30'b0, level}, 32'd1);
        check("ori_head", out_instr, 32'h3405FFFF);

        // illegal accept with simultaneous pop: only the level moves
        req(1'b1, 4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        tick();
        check("ill_pop_level", {30'b0, level}, 32'd0);
        check("ill_pop_pulse", {31'b0, illegal}, 32'd1);
        check("ill_pop_cnt", {24'b0, illegal_cnt}, 32'd1);
        req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        tick();
        check("ill_pulse_one_cycle", {31'b0, illegal}, 32'd0);

        // 256 back-to-back op=12 requests: counter saturates, FIFO untouched
        out_ready = 1'b0;
        pulses  = 0;
        lvl_bad = 1'b0;
        req(1'b1, 4'd12, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1);
        for (int i = 0; i < 256; i++) begin
            tick();
            if (illegal) pulses++;
            if (level != 2'd0) lvl_bad = 1'b1;
            if (i == 252) check("ill_cnt_254", {24'b0, illegal_cnt}, 32'd254);
            if (i == 253) check("ill_cnt_255", {24'b0, illegal_cnt}, 32'd255);
        end
        req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        check("ill_pulses", pulses, 32'd256);
        check("ill_level_zero", {31'b0, lvl_bad}, 32'd0);
        check("ill_cnt_sat", {24'b0, illegal_cnt}, 32'd255);
        tick();
        check("ill_pulse_end", {31'b0, illegal}, 32'd0);

        // asynchronous reset mid-cycle at level 2
        req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        tick();
        req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        check("pre_rst_level", {30'b0, level}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("async_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_level", {30'b0, level}, 32'd0);
        check("async_cnt", {24'b0, illegal_cnt}, 32'd0);
        check("async_out_instr", out_instr, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check("after_rst_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("after_rst_empty", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
